// File: rtl/wallace_mac.sv
// Burst multiply-accumulate around a word-level Wallace-tree 8x8 multiplier.
// Optional macro SATURATE_EN: clamp the accumulator on carry instead of wrapping.

module wallace_mul8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  logic [15:0] w_pp [8];
  logic [15:0] w_s1, w_c1, w_s2, w_c2;
  logic [15:0] w_s3, w_c3, w_s4, w_c4;
  logic [15:0] w_s5, w_c5, w_s6, w_c6;

  function automatic logic [15:0] csa_s(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z
  );
    logic [15:0] m;
    m = (x & y) | (x & z) | (y & z);
    return {m[14:0], 1'b0};
  endfunction

  // Partial products: row i is a gated by b[i], shifted left by i
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = {8'd0, i_a & {8{i_b[i]}}} << i;
    end
  end

  // Four 3:2 reduction layers (8 -> 6 -> 4 -> 3 -> 2 rows), then one adder
  always_comb begin
    w_s1 = csa_s(w_pp[0], w_pp[1], w_pp[2]);
    w_c1 = csa_c(w_pp[0], w_pp[1], w_pp[2]);
    w_s2 = csa_s(w_pp[3], w_pp[4], w_pp[5]);
    w_c2 = csa_c(w_pp[3], w_pp[4], w_pp[5]);
    w_s3 = csa_s(w_s1, w_c1, w_s2);
    w_c3 = csa_c(w_s1, w_c1, w_s2);
    w_s4 = csa_s(w_c2, w_pp[6], w_pp[7]);
    w_c4 = csa_c(w_c2, w_pp[6], w_pp[7]);
    w_s5 = csa_s(w_s3, w_c3, w_s4);
    w_c5 = csa_c(w_s3, w_c3, w_s4);
    w_s6 = csa_s(w_s5, w_c5, w_c4);
    w_c6 = csa_c(w_s5, w_c5, w_c4);
    o_p  = w_s6 + w_c6;
  end

endmodule

module wallace_mac #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_a_q;
  logic [7:0]       r_b_q;
  logic             r_p_v;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;
  logic [15:0]      w_p;
  logic             w_accept;
  logic             w_start;
  logic             w_take;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;

  wallace_mul8 u_mul (
    .i_a (r_a_q),
    .i_b (r_b_q),
    .o_p (w_p)
  );

  assign w_accept = (r_state == S_RUN) && in_valid;
  assign w_start  = (r_state == S_IDLE) && start;
  assign w_take   = r_out_valid && out_ready;

  // Widened add exposes the carry out of the accumulator
  always_comb begin
    w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(w_p);
    w_carry   = w_sum[ACC_W];
`ifdef SATURATE_EN
    w_acc_nxt = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
    w_acc_nxt = w_sum[ACC_W-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) w_state_nxt = S_RUN;
          else           w_state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        if (w_accept && r_cnt == CNT_W'(1))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_take) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    in_ready = (r_state == S_RUN);
    busy     = (r_state != S_IDLE);
  end

  // Operand capture, pair counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a_q <= '0;
      r_b_q <= '0;
      r_p_v <= 1'b0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_p_v <= w_accept;
      if (w_accept) begin
        r_a_q <= a;
        r_b_q <= b;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_start) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= len;
      end else if (r_p_v) begin
        r_acc <= w_acc_nxt;
        if (w_carry) r_ovf <= 1'b1;
      end
    end
  end

  // Result valid rises one cycle into DONE and drops after the handshake
  always_ff @(posedge clk) begin
    if (rst) r_out_valid <= 1'b0;
    else     r_out_valid <= (r_state == S_DONE) && !w_take;
  end

  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_wallace_mac.sv
// Directed bench for wallace_mac: a 24-bit and a 16-bit accumulator
// instance driven by the same stimulus.

module tb_wallace_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        ir24, ov24, busy24, ovf24;
  logic [23:0] acc24;
  logic        ir16, ov16, busy16, ovf16;
  logic [15:0] acc16;

  int n_tot = 0;
  int n_bad = 0;
  int hs = 0;
  int rdy = 0;
  int lat;
  int h0;
  int r0;
  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic [31:0] exp16;

  always #5 clk = ~clk;

  wallace_mac #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (ir24),
    .a         (a),
    .b         (b),
    .out_valid (ov24),
    .out_ready (out_ready),
    .acc_out   (acc24),
    .busy      (busy24),
    .ovf       (ovf24)
  );

  wallace_mac #(.ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (ir16),
    .a         (a),
    .b         (b),
    .out_valid (ov16),
    .out_ready (out_ready),
    .acc_out   (acc16),
    .busy      (busy16),
    .ovf       (ovf16)
  );

  always @(posedge clk) begin
    if (in_valid && ir24) hs++;
    if (ir24) rdy++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_burst(
    input  int n,
    input  bit gaps,
    output int l
  );
    int i = 0;
    int g = 0;
    int k;
    bit ph = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    while (i < n && g < 100) begin
      if (gaps && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a = va[i];
        b = vb[i];
        if (ir24) i++;
      end
      ph = ~ph;
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    k = 1;
    while (!ov24 && k < 20) begin
      @(negedge clk);
      k++;
    end
    l = k - 1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("take_ov", 32'(ov24), 0);
    chk("take_busy", 32'(busy24), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ir", 32'(ir24), 0);
    chk("rst_ov", 32'(ov24), 0);
    chk("rst_busy", 32'(busy24), 0);
    chk("rst_ovf", 32'(ovf24), 0);
    chk("rst_acc", 32'(acc24), 0);
    rst = 1'b0;

    va[0] = 3;   vb[0] = 4;
    va[1] = 5;   vb[1] = 6;
    va[2] = 255; vb[2] = 255;
    h0 = hs;
    run_burst(3, 1'b0, lat);
    chk("t1_lat", 32'(lat), 2);
    chk("t1_acc", 32'(acc24), 65067);
    chk("t1_ovf", 32'(ovf24), 0);
    chk("t1_hs", 32'(hs - h0), 3);
    consume();

    r0 = rdy;
    @(negedge clk);
    start = 1'b1;
    len = 0;
    @(negedge clk);
    start = 1'b0;
    chk("t2_ov_e1", 32'(ov24), 0);
    chk("t2_busy", 32'(busy24), 1);
    @(negedge clk);
    chk("t2_ov_e2", 32'(ov24), 1);
    chk("t2_acc", 32'(acc24), 0);
    chk("t2_rdy", 32'(rdy - r0), 0);
    consume();

    for (int i = 0; i < 4; i++) begin
      va[i] = 1;
      vb[i] = 1;
    end
    h0 = hs;
    run_burst(4, 1'b1, lat);
    chk("t3_acc", 32'(acc24), 4);
    chk("t3_hs", 32'(hs - h0), 4);
    chk("t3_lat", 32'(lat), 2);
    consume();

    va[0] = 255; vb[0] = 255;
    va[1] = 255; vb[1] = 255;
    run_burst(2, 1'b0, lat);
`ifdef SATURATE_EN
    exp16 = 65535;
`else
    exp16 = 64514;
`endif
    chk("t4_acc16", 32'(acc16), exp16);
    chk("t4_ovf16", 32'(ovf16), 1);
    chk("t4_ov16", 32'(ov16), 1);
    chk("t4_acc24", 32'(acc24), 130050);
    chk("t4_ovf24", 32'(ovf24), 0);

    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      start = (j == 3);
      len = 5;
    end
    start = 1'b0;
    chk("t6_acc", 32'(acc24), 130050);
    chk("t6_ov", 32'(ov24), 1);
    chk("t6_busy", 32'(busy24), 1);
    chk("t6_ir", 32'(ir24), 0);
    chk("t6_acc16", 32'(acc16), exp16);
    consume();

    @(negedge clk);
    start = 1'b1;
    len = 5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a = 9;
    b = 9;
    @(negedge clk);
    a = 7;
    b = 7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_busy_pre", 32'(busy24), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy24), 0);
    chk("t5_ov", 32'(ov24), 0);
    chk("t5_ir", 32'(ir24), 0);
    chk("t5_acc", 32'(acc24), 0);
    va[0] = 2;
    vb[0] = 3;
    run_burst(1, 1'b0, lat);
    chk("t5_res", 32'(acc24), 6);
    chk("t5_lat", 32'(lat), 2);
    consume();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
